// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: DIFF = A - B - BIN, LSB first, one bit per clock.
// Define SERIAL_SUBTRACTOR_OVF_EN to add the signed-overflow output ovf_o.
module serial_subtractor #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic             bin_i,
   output logic             busy_o,
   output logic             done_o,
   output logic [WIDTH-1:0] diff_o,
   output logic             bout_o
`ifdef SERIAL_SUBTRACTOR_OVF_EN
   ,
   output logic             ovf_o
`endif
);

   localparam int CW = $clog2(WIDTH) + 1;
   localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] aSr_q, aSr_d;
   logic [WIDTH-1:0] bSr_q, bSr_d;
   logic             borrow_q, borrow_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] diff_q, diff_d;
   logic             bout_q, bout_d;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
   logic             ovf_q, ovf_d;
`endif

   logic aBit, bBit, bitDiff, brNext;

   // Single full-subtractor cell fed by the operand LSBs and the borrow flop.
   assign aBit    = aSr_q[0];
   assign bBit    = bSr_q[0];
   assign bitDiff = aBit ^ bBit ^ borrow_q;
   assign brNext  = (~aBit & bBit) | (~(aBit ^ bBit) & borrow_q);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         aSr_q    <= '0;
         bSr_q    <= '0;
         borrow_q <= 1'b0;
         cnt_q    <= '0;
         diff_q   <= '0;
         bout_q   <= 1'b0;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
         ovf_q    <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         aSr_q    <= aSr_d;
         bSr_q    <= bSr_d;
         borrow_q <= borrow_d;
         cnt_q    <= cnt_d;
         diff_q   <= diff_d;
         bout_q   <= bout_d;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
         ovf_q    <= ovf_d;
`endif
      end
   end

   always_comb begin
      state_d  = state_q;
      aSr_d    = aSr_q;
      bSr_d    = bSr_q;
      borrow_d = borrow_q;
      cnt_d    = cnt_q;
      diff_d   = diff_q;
      bout_d   = bout_q;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
      ovf_d    = ovf_q;
`endif
      busy_o   = 1'b0;
      done_o   = 1'b0;

      case (state_q)
         IDLE: begin
            if (start_i) begin
               aSr_d    = a_i;
               bSr_d    = b_i;
               borrow_d = bin_i;
               cnt_d    = '0;
               state_d  = SHIFT;
            end
         end
         SHIFT: begin
            busy_o   = 1'b1;
            diff_d   = {bitDiff, diff_q[WIDTH-1:1]};
            aSr_d    = {1'b0, aSr_q[WIDTH-1:1]};
            bSr_d    = {1'b0, bSr_q[WIDTH-1:1]};
            borrow_d = brNext;
            cnt_d    = cnt_q + CW'(1);
            // On the last bit the shift registers hold the captured operand MSBs.
            if (cnt_q == LAST_CNT) begin
               bout_d  = brNext;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
               ovf_d   = (aBit != bBit) && (bitDiff != aBit);
`endif
               state_d = DONE;
            end
         end
         DONE: begin
            done_o  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign diff_o = diff_q;
   assign bout_o = bout_q;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
   assign ovf_o  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: 8-bit and 16-bit instances, directed table, handshake corner cases
// and a randomized sweep against an arithmetic reference model.
module tb_serial_subtractor;

   logic clk = 1'b0;
   logic rst_n;

   logic        start8, bin8, busy8, done8, bout8;
   logic [7:0]  a8, b8, diff8;
   logic        start16, bin16, busy16, done16, bout16;
   logic [15:0] a16, b16, diff16;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
   logic        ovf8, ovf16;
`endif

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   serial_subtractor #(.WIDTH(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .start_i(start8), .a_i(a8), .b_i(b8), .bin_i(bin8),
      .busy_o(busy8), .done_o(done8), .diff_o(diff8), .bout_o(bout8)
`ifdef SERIAL_SUBTRACTOR_OVF_EN
      , .ovf_o(ovf8)
`endif
   );

   serial_subtractor #(.WIDTH(16)) dut16 (
      .clk(clk), .rst_n(rst_n), .start_i(start16), .a_i(a16), .b_i(b16), .bin_i(bin16),
      .busy_o(busy16), .done_o(done16), .diff_o(diff16), .bout_o(bout16)
`ifdef SERIAL_SUBTRACTOR_OVF_EN
      , .ovf_o(ovf16)
`endif
   );

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic       bin;
      logic [7:0] diff;
      logic       bout;
      logic       ovf;
   } vec_t;

   vec_t tbl[9];

   // Every comparison funnels through here so the summary counts stay honest.
   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input bit wide, input logic [15:0] a, input logic [15:0] b,
                                input logic bin, input logic start);
      if (wide) begin
         a16 = a; b16 = b; bin16 = bin; start16 = start;
      end else begin
         a8 = a[7:0]; b8 = b[7:0]; bin8 = bin; start8 = start;
      end
   endtask

   function automatic logic curDone(input bit wide);
      return wide ? done16 : done8;
   endfunction

   function automatic logic curBusy(input bit wide);
      return wide ? busy16 : busy8;
   endfunction

   // Bounded wait for done; n counts clock edges after the accepting edge.
   task automatic waitDone(input bit wide, output int n, output int busyCnt);
      n = 0;
      busyCnt = 0;
      while (!curDone(wide) && n < 40) begin
         if (curBusy(wide)) busyCnt++;
         @(posedge clk); #1;
         n++;
      end
   endtask

   // Reference model: plain integer arithmetic on the operand values.
   task automatic refModel(input int w, input logic [15:0] a, input logic [15:0] b, input logic bin,
                           output logic [15:0] d, output logic bo, output logic ov);
      int r;
      logic [15:0] mask;
      r    = int'(a) - int'(b) - int'(bin);
      mask = 16'((1 << w) - 1);
      d    = 16'(r) & mask;
      bo   = (r < 0);
      ov   = (a[w-1] != b[w-1]) && (d[w-1] != a[w-1]);
   endtask

   task automatic runOp(input bit wide, input logic [15:0] a, input logic [15:0] b, input logic bin,
                        input logic [15:0] expDiff, input logic expBout, input logic expOvf,
                        input string tag);
      int n, busyCnt, w;
      w = wide ? 16 : 8;
      applyStimulus(wide, a, b, bin, 1'b1);
      @(posedge clk); #1;
      applyStimulus(wide, a, b, bin, 1'b0);
      waitDone(wide, n, busyCnt);
      checkOutput({tag, "_latency"}, n, w);
      checkOutput({tag, "_busycycles"}, busyCnt, w);
      checkOutput({tag, "_diff"}, wide ? diff16 : {8'h00, diff8}, expDiff);
      checkOutput({tag, "_bout"}, wide ? bout16 : bout8, expBout);
`ifdef SERIAL_SUBTRACTOR_OVF_EN
      checkOutput({tag, "_ovf"}, wide ? ovf16 : ovf8, expOvf);
`else
      if (expOvf === 1'bx) $display("[TB] unexpected unknown ovf expectation");
`endif
      @(posedge clk); #1;
      checkOutput({tag, "_donepulse"}, curDone(wide), 1'b0);
   endtask

   initial begin
      int n, busyCnt, extra;
      logic [15:0] ra, rb, rd;
      logic rbin, rbo, rov;

      tbl[0] = '{8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0};
      tbl[1] = '{8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0};
      tbl[2] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0};
      tbl[3] = '{8'h5A, 8'h5A, 1'b0, 8'h00, 1'b0, 1'b0};
      tbl[4] = '{8'h10, 8'h01, 1'b0, 8'h0F, 1'b0, 1'b0};
      tbl[5] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1};
      tbl[6] = '{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1};
      tbl[7] = '{8'hC8, 8'h37, 1'b0, 8'h91, 1'b0, 1'b0};
      tbl[8] = '{8'hFF, 8'h00, 1'b1, 8'hFE, 1'b0, 1'b0};

      rst_n = 1'b1;
      applyStimulus(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
      applyStimulus(1'b1, 16'h0, 16'h0, 1'b0, 1'b0);
      #3 rst_n = 1'b0;
      #2;
      checkOutput("reset_busy8", busy8, 1'b0);
      checkOutput("reset_done8", done8, 1'b0);
      checkOutput("reset_diff8", diff8, 8'h00);
      checkOutput("reset_bout8", bout8, 1'b0);
      checkOutput("reset_busy16", busy16, 1'b0);
      checkOutput("reset_diff16", diff16, 16'h0000);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < 9; i++)
         runOp(1'b0, {8'h00, tbl[i].a}, {8'h00, tbl[i].b}, tbl[i].bin,
               {8'h00, tbl[i].diff}, tbl[i].bout, tbl[i].ovf, $sformatf("tbl%0d", i));

      // Back-to-back with start held high; operands changed while busy must not matter.
      applyStimulus(1'b0, 16'h03, 16'h05, 1'b0, 1'b1);
      @(posedge clk); #1;
      applyStimulus(1'b0, 16'h00, 16'h00, 1'b1, 1'b1);
      waitDone(1'b0, n, busyCnt);
      checkOutput("b2b_first_latency", n, 8);
      checkOutput("b2b_first_diff", diff8, 8'hFE);
      checkOutput("b2b_first_bout", bout8, 1'b1);
      @(posedge clk); #1;
      checkOutput("b2b_idle_busy", busy8, 1'b0);
      checkOutput("b2b_idle_done", done8, 1'b0);
      @(posedge clk); #1;
      checkOutput("b2b_accept_busy", busy8, 1'b1);
      start8 = 1'b0;
      waitDone(1'b0, n, busyCnt);
      checkOutput("b2b_second_latency", n, 8);
      checkOutput("b2b_second_diff", diff8, 8'hFF);
      checkOutput("b2b_second_bout", bout8, 1'b1);
      @(posedge clk); #1;

      // Asynchronous reset in the middle of a shift aborts the operation.
      applyStimulus(1'b0, 16'hC8, 16'h37, 1'b0, 1'b1);
      @(posedge clk); #1;
      start8 = 1'b0;
      repeat (4) begin @(posedge clk); #1; end
      checkOutput("pre_reset_busy", busy8, 1'b1);
      rst_n = 1'b0;
      #1;
      checkOutput("midreset_busy", busy8, 1'b0);
      checkOutput("midreset_done", done8, 1'b0);
      checkOutput("midreset_diff", diff8, 8'h00);
      checkOutput("midreset_bout", bout8, 1'b0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      extra = 0;
      repeat (12) begin @(posedge clk); #1; if (done8) extra++; end
      checkOutput("midreset_no_done", extra, 0);
      runOp(1'b0, 16'h10, 16'h01, 1'b0, 16'h0F, 1'b0, 1'b0, "after_reset");

      // A start pulsed during SHIFT is ignored.
      applyStimulus(1'b0, 16'h5A, 16'h5A, 1'b0, 1'b1);
      @(posedge clk); #1;
      start8 = 1'b0;
      repeat (2) begin @(posedge clk); #1; end
      applyStimulus(1'b0, 16'hFF, 16'h01, 1'b0, 1'b1);
      @(posedge clk); #1;
      start8 = 1'b0;
      waitDone(1'b0, n, busyCnt);
      checkOutput("ignore_latency", n, 5);
      checkOutput("ignore_diff", diff8, 8'h00);
      checkOutput("ignore_bout", bout8, 1'b0);
      extra = 0;
      repeat (12) begin @(posedge clk); #1; if (done8) extra++; end
      checkOutput("ignore_single_done", extra, 0);
      checkOutput("ignore_idle_busy", busy8, 1'b0);

      for (int w = 0; w < 2; w++) begin
         for (int i = 0; i < 1000; i++) begin
            ra   = 16'($urandom);
            rb   = 16'($urandom);
            rbin = 1'($urandom);
            if (w == 0) begin
               ra[15:8] = 8'h00;
               rb[15:8] = 8'h00;
            end
            refModel(w == 0 ? 8 : 16, ra, rb, rbin, rd, rbo, rov);
            runOp(w == 1, ra, rb, rbin, rd, rbo, rov, $sformatf("rnd%0d_%0d", w == 0 ? 8 : 16, i));
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
